// File: rtl/po_c_deserializer_if.sv
// -----------------------------------------------------------------------------
// po_c_deserializer_if
// Bundles the serial input side and the parallel valid/ready output side of
// the po_c deserializer.
//
// Signals:
//   pi_bit     serial data bit taken from the upstream po_c stream
//   pi_en      sample strobe; pi_bit is only meaningful when pi_en=1
//   pi_ready   downstream consumer can accept the held word
//   po_data    held parallel word, first captured bit at the MSB
//   po_valid   po_data/po_ones hold a word that has not been consumed
//   po_ones    population count of po_data
//   po_overrun sticky flag, a completed word was dropped
//
// Modports:
//   master  the environment: drives the serial side and the ready
//   slave   the deserializer itself
// -----------------------------------------------------------------------------
interface po_c_deserializer_if #(
   parameter int DATA_W = 8
);
   localparam int CNT_W = $clog2(DATA_W + 1);

   logic              pi_bit;
   logic              pi_en;
   logic              pi_ready;
   logic [DATA_W-1:0] po_data;
   logic              po_valid;
   logic [CNT_W-1:0]  po_ones;
   logic              po_overrun;

   modport master (
      output pi_bit,
      output pi_en,
      output pi_ready,
      input  po_data,
      input  po_valid,
      input  po_ones,
      input  po_overrun
   );

   modport slave (
      input  pi_bit,
      input  pi_en,
      input  pi_ready,
      output po_data,
      output po_valid,
      output po_ones,
      output po_overrun
   );
endinterface

// File: rtl/po_c_deserializer.sv
// -----------------------------------------------------------------------------
// po_c_deserializer
// Samples the one-bit po_c stream on enabled clock edges and packs DATA_W
// consecutive enabled bits into a word, MSB first. Each finished word sits in
// a one-entry valid/ready buffer together with its ones count. A word that
// finishes while the buffer is full and not draining is dropped and latches
// the sticky overrun flag.
//
// Ports:
//   clk    system clock, everything on the rising edge
//   rst_n  synchronous active-low reset
//   bus    po_c_deserializer_if.slave (serial input, parallel output)
// -----------------------------------------------------------------------------
module po_c_deserializer #(
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   po_c_deserializer_if.slave    bus
);
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int BIT_W = $clog2(DATA_W);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_t;

   // Only the low DATA_W-1 bits of the shift history are ever needed: the
   // bit arriving on the completing edge supplies the LSB directly.
   logic [DATA_W-2:0] shreg;
   logic [BIT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  ones_acc;
   buf_state_t        state;
   logic [DATA_W-1:0] data_q;
   logic [CNT_W-1:0]  ones_q;
   logic              overrun_q;

   logic              complete;
   logic              drain;
   logic [DATA_W-1:0] word;
   logic [CNT_W-1:0]  word_ones;

   // The word and its count are formed from the current history plus the
   // incoming bit, so a completed word is loaded on the very edge that
   // captures its last bit.
   always_comb begin
      complete  = bus.pi_en && (bit_cnt == BIT_W'(DATA_W - 1));
      drain     = (state == FULL) && bus.pi_ready;
      word      = {shreg, bus.pi_bit};
      word_ones = ones_acc + CNT_W'(bus.pi_bit);
   end

   // Collection path and output buffer in one registered block. A drain and
   // a completion on the same edge reload the buffer without a bubble; a
   // completion against a full, non-draining buffer is dropped and flagged.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg     <= '0;
         bit_cnt   <= '0;
         ones_acc  <= '0;
         state     <= EMPTY;
         data_q    <= '0;
         ones_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (bus.pi_en) begin
            shreg <= word[DATA_W-2:0];
            if (complete) begin
               bit_cnt  <= '0;
               ones_acc <= '0;
            end else begin
               bit_cnt  <= bit_cnt + BIT_W'(1);
               ones_acc <= word_ones;
            end
         end

         case (state)
            EMPTY: begin
               if (complete) begin
                  data_q <= word;
                  ones_q <= word_ones;
                  state  <= FULL;
               end
            end
            FULL: begin
               if (complete) begin
                  if (bus.pi_ready) begin
                     data_q <= word;
                     ones_q <= word_ones;
                  end else begin
                     overrun_q <= 1'b1;
                  end
               end else if (drain) begin
                  state <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   // All outputs come straight from flops; po_valid is the buffer state.
   assign bus.po_data    = data_q;
   assign bus.po_ones    = ones_q;
   assign bus.po_valid   = (state == FULL);
   assign bus.po_overrun = overrun_q;

endmodule

// File: tb/tb_po_c_deserializer.sv
// -----------------------------------------------------------------------------
// tb_po_c_deserializer
// Directed scenarios plus a randomized run for po_c_deserializer (DATA_W=8).
// A reference model built from the word/buffer rules (bit queue, plain
// arithmetic, a held-word record) predicts every output after each edge.
// -----------------------------------------------------------------------------
module tb_po_c_deserializer;
   localparam int DATA_W = 8;
   localparam int CNT_W  = $clog2(DATA_W + 1);

   logic clk = 1'b0;
   logic rst_n;

   po_c_deserializer_if #(.DATA_W(DATA_W)) bus ();

   po_c_deserializer #(.DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model state
   bit             m_bits[$];
   logic [7:0]     m_data    = '0;
   int             m_ones    = 0;
   logic           m_valid   = 1'b0;
   logic           m_overrun = 1'b0;

   // Advance the model by one clock edge using the inputs seen at that edge.
   task automatic model_edge(input logic b, input logic en, input logic rdy, input logic rn);
      int         nw;
      bit         done;
      bit         drain;
      if (!rn) begin
         m_bits.delete();
         m_data    = '0;
         m_ones    = 0;
         m_valid   = 1'b0;
         m_overrun = 1'b0;
      end else begin
         drain = m_valid && rdy;
         done  = 0;
         nw    = 0;
         if (en) begin
            m_bits.push_back(b);
            if (m_bits.size() == DATA_W) begin
               done = 1;
               foreach (m_bits[i]) nw = nw * 2 + int'(m_bits[i]);
               m_bits.delete();
            end
         end
         if (done) begin
            if (!m_valid || drain) begin
               m_data  = nw[7:0];
               m_ones  = $countones(nw);
               m_valid = 1'b1;
            end else begin
               m_overrun = 1'b1;
            end
         end else if (drain) begin
            m_valid = 1'b0;
         end
      end
   endtask

   // Compare every DUT output with the model.
   task automatic check_output(input string tag);
      tests++;
      assert (bus.po_valid === m_valid) else begin
         fails++;
         $error("[TB] FAIL %s po_valid observed=%b expected=%b", tag, bus.po_valid, m_valid);
      end
      tests++;
      assert (bus.po_overrun === m_overrun) else begin
         fails++;
         $error("[TB] FAIL %s po_overrun observed=%b expected=%b", tag, bus.po_overrun, m_overrun);
      end
      tests++;
      assert (bus.po_data === m_data) else begin
         fails++;
         $error("[TB] FAIL %s po_data observed=%h expected=%h", tag, bus.po_data, m_data);
      end
      tests++;
      assert (bus.po_ones === CNT_W'(m_ones)) else begin
         fails++;
         $error("[TB] FAIL %s po_ones observed=%0d expected=%0d", tag, bus.po_ones, m_ones);
      end
   endtask

   // Directed check of one observed value against a fixed expectation.
   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, let the edge happen, update the model and check.
   task automatic apply_stimulus(input logic b, input logic en, input logic rdy,
                                 input logic rn, input string tag);
      bus.pi_bit   = b;
      bus.pi_en    = en;
      bus.pi_ready = rdy;
      rst_n        = rn;
      @(posedge clk);
      model_edge(b, en, rdy, rn);
      #1;
      check_output(tag);
   endtask

   // Send one word MSB first; rdy applies to all but the last bit.
   task automatic send_word(input logic [7:0] w, input logic rdy, input logic rdy_last,
                            input bit gaps, input string tag);
      logic [7:0] wv;
      wv = w;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         apply_stimulus(wv[i], 1'b1, (i == 0) ? rdy_last : rdy, 1'b1, tag);
         if (gaps && i != 0) begin
            for (int g = 0; g < int'($urandom_range(3, 1)); g++)
               apply_stimulus(1'($urandom), 1'b0, rdy, 1'b1, {tag, "_gap"});
         end
      end
   endtask

   initial begin
      bus.pi_bit   = 1'b0;
      bus.pi_en    = 1'b0;
      bus.pi_ready = 1'b0;
      rst_n        = 1'b0;

      // Reset with random inputs, then release
      for (int i = 0; i < 3; i++)
         apply_stimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, "reset");
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, "reset_release");
      check_value("reset_release_valid", 32'(bus.po_valid), 32'd0);

      // Basic word 8'hB2
      send_word(8'hB2, 1'b1, 1'b1, 0, "basic");
      check_value("basic_data", 32'(bus.po_data), 32'hB2);
      check_value("basic_ones", 32'(bus.po_ones), 32'd4);
      check_value("basic_valid", 32'(bus.po_valid), 32'd1);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, "basic_drain");
      check_value("basic_valid_one_cycle", 32'(bus.po_valid), 32'd0);

      // Same word with enable gaps
      send_word(8'hB2, 1'b1, 1'b1, 1, "gaps");
      check_value("gaps_data", 32'(bus.po_data), 32'hB2);
      check_value("gaps_ones", 32'(bus.po_ones), 32'd4);
      check_value("gaps_valid", 32'(bus.po_valid), 32'd1);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, "gaps_drain");

      // Backpressure overrun
      send_word(8'hFF, 1'b0, 1'b0, 0, "ovr_first");
      send_word(8'h0F, 1'b0, 1'b0, 0, "ovr_second");
      check_value("ovr_data", 32'(bus.po_data), 32'hFF);
      check_value("ovr_ones", 32'(bus.po_ones), 32'd8);
      check_value("ovr_valid", 32'(bus.po_valid), 32'd1);
      check_value("ovr_flag", 32'(bus.po_overrun), 32'd1);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, "ovr_drain");
      check_value("ovr_drain_valid", 32'(bus.po_valid), 32'd0);
      check_value("ovr_sticky", 32'(bus.po_overrun), 32'd1);

      // Simultaneous drain and completion
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, "sim_reset");
      send_word(8'hA5, 1'b0, 1'b0, 0, "sim_first");
      for (int i = DATA_W - 1; i >= 0; i--) begin
         logic [7:0] w2;
         w2 = 8'h3C;
         apply_stimulus(w2[i], 1'b1, (i == 0), 1'b1, "sim_second");
         check_value("sim_valid_held", 32'(bus.po_valid), 32'd1);
      end
      check_value("sim_data", 32'(bus.po_data), 32'h3C);
      check_value("sim_ones", 32'(bus.po_ones), 32'd4);
      check_value("sim_overrun", 32'(bus.po_overrun), 32'd0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, "sim_drain");

      // Reset mid-word
      for (int i = 0; i < 5; i++)
         apply_stimulus(1'($urandom), 1'b1, 1'b1, 1'b1, "mid_partial");
      apply_stimulus(1'($urandom), 1'b1, 1'b1, 1'b0, "mid_reset");
      send_word(8'h81, 1'b1, 1'b1, 0, "mid_word");
      check_value("mid_data", 32'(bus.po_data), 32'h81);
      check_value("mid_ones", 32'(bus.po_ones), 32'd2);
      check_value("mid_valid", 32'(bus.po_valid), 32'd1);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 600; i++)
         apply_stimulus(1'($urandom), ($urandom_range(3, 0) != 0),
                        1'($urandom), ($urandom_range(63, 0) != 0), "random");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Safety bound so the run always ends on its own
   initial begin
      #200000;
      fails++;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "[TB] timeout");
   end

endmodule
